// File: rtl/control_loop_math_mc.sv
// Multi-channel PI control-loop arithmetic core.
// One shared radix-2 signed shift-add multiplier is time-multiplexed across
// NCH loops; per-channel e_prev/adj_prev history lives in this block.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for arm/clr; clr clears a channel, arm starts a run
//   S_DT    | dt  = SEC_PER_CYCLE * cycles               (W clocks)
//   S_IDT   | idt = cl_I * dt                            (W clocks)
//   S_EPIDT | a   = sat(cl_P + idt) * e_cur              (W clocks)
//   S_EP    | b   = cl_P * e_prev[ch]                    (W clocks)
//   S_SUM   | s   = adj_prev[ch] + a - b, W+2 bits
//   S_CLAMP | adj = s limited to [ADJ_MIN, ADJ_MAX]
//   S_DONE  | first clock commits results; finished held while arm=1
module control_loop_math_mc #(
    parameter int CONSTS_WHOLE    = 21,
    parameter int CONSTS_FRAC     = 43,
    parameter int ADC_WID         = 18,
    parameter int CYCLE_COUNT_WID = 18,
    parameter logic [CONSTS_WHOLE+CONSTS_FRAC-1:0] SEC_PER_CYCLE = 'b10101011110011000,
    parameter int NCH             = 4,
    parameter logic signed [CONSTS_WHOLE+CONSTS_FRAC-1:0] ADJ_MAX =
        {1'b0, {(CONSTS_WHOLE+CONSTS_FRAC-1){1'b1}}},
    parameter logic signed [CONSTS_WHOLE+CONSTS_FRAC-1:0] ADJ_MIN =
        {1'b1, {(CONSTS_WHOLE+CONSTS_FRAC-2){1'b0}}, 1'b1},
    localparam int W   = CONSTS_WHOLE + CONSTS_FRAC,
    localparam int EW  = ADC_WID + 1,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_L,
    input  logic                       arm,
    input  logic [CHW-1:0]             ch,
    input  logic                       clr,
    input  logic signed [ADC_WID-1:0]  setpt,
    input  logic signed [ADC_WID-1:0]  measured,
    input  logic signed [W-1:0]        cl_P,
    input  logic signed [W-1:0]        cl_I,
    input  logic [CYCLE_COUNT_WID-1:0] cycles,
    output logic                       finished,
    output logic                       err,
    output logic                       clamped,
    output logic signed [EW-1:0]       e_cur,
    output logic signed [W-1:0]        adj_val
);

    localparam int NSLOT = 2 ** CHW;
    localparam int CW    = $clog2(W);

    localparam logic signed [2*W-1:0] PMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] PMIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [W+1:0]   LIM_HI = {{2{ADJ_MAX[W-1]}}, ADJ_MAX};
    localparam logic signed [W+1:0]   LIM_LO = {{2{ADJ_MIN[W-1]}}, ADJ_MIN};

    typedef enum logic [2:0] {
        S_IDLE, S_DT, S_IDT, S_EPIDT, S_EP, S_SUM, S_CLAMP, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CHW-1:0]          ch_r;
    logic signed [W-1:0]     p_r, i_r;
    logic signed [2*W-1:0]   mcand, acc, addend, acc_nxt;
    logic [W-1:0]            mplier;
    logic [CW-1:0]           cnt;
    logic signed [W-1:0]     a_r, b_r, adj_r, p_sat, adj_c;
    logic signed [W+1:0]     s_r, s_nxt;
    logic                    clamp_r, hit, run_bad, clr_err, err_r;
    logic                    ch_ok, mul_last;
    logic signed [EW-1:0]    e_prev   [NSLOT];
    logic signed [W-1:0]     adj_prev [NSLOT];

    // Drop a full-width product back to Q format and saturate to W bits.
    function automatic logic signed [W-1:0] sat_prod(input logic signed [2*W-1:0] p);
        logic signed [2*W-1:0] sh;
        sh = p >>> CONSTS_FRAC;
        if (sh > PMAX)      sat_prod = PMAX[W-1:0];
        else if (sh < PMIN) sat_prod = PMIN[W-1:0];
        else                sat_prod = sh[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] x,
                                                    input logic signed [W-1:0] y);
        logic [W:0] sum;
        sum = {x[W-1], x} + {y[W-1], y};
        if (sum[W] != sum[W-1]) sat_add = sum[W] ? PMIN[W-1:0] : PMAX[W-1:0];
        else                    sat_add = sum[W-1:0];
    endfunction

    function automatic logic signed [2*W-1:0] ext2(input logic signed [W-1:0] x);
        ext2 = {{W{x[W-1]}}, x};
    endfunction

    // The error is a whole number; it enters the multiplier as a Q value so
    // the common >>FRAC truncation leaves the product in Q format.
    function automatic logic signed [W-1:0] to_q(input logic signed [EW-1:0] e);
        to_q = {{(W-EW-CONSTS_FRAC){e[EW-1]}}, e, {CONSTS_FRAC{1'b0}}};
    endfunction

    assign ch_ok    = (int'(ch) < NCH);
    assign mul_last = (cnt == '0);
    assign err      = err_r | clr_err;

    // One multiplier step; the last step weighs the multiplier sign bit negatively.
    always_comb begin
        addend  = mplier[0] ? mcand : '0;
        acc_nxt = mul_last ? (acc - addend) : (acc + addend);
        p_sat   = sat_prod(acc_nxt);
        s_nxt   = {{2{adj_prev[ch_r][W-1]}}, adj_prev[ch_r]}
                + {{2{a_r[W-1]}}, a_r}
                - {{2{b_r[W-1]}}, b_r};
    end

    // Output limiter; the only place adj is saturated.
    always_comb begin
        adj_c = s_r[W-1:0];
        hit   = 1'b0;
        if (s_r > LIM_HI) begin
            adj_c = ADJ_MAX;
            hit   = 1'b1;
        end else if (s_r < LIM_LO) begin
            adj_c = ADJ_MIN;
            hit   = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!clr && arm) state_nxt = ch_ok ? S_DT : S_DONE;
            S_DT:    if (mul_last) state_nxt = S_IDT;
            S_IDT:   if (mul_last) state_nxt = S_EPIDT;
            S_EPIDT: if (mul_last) state_nxt = S_EP;
            S_EP:    if (mul_last) state_nxt = S_SUM;
            S_SUM:   state_nxt = S_CLAMP;
            S_CLAMP: state_nxt = S_DONE;
            S_DONE:  if (finished && !arm) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath, channel history and registered outputs.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            ch_r     <= '0;
            p_r      <= '0;
            i_r      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            s_r      <= '0;
            adj_r    <= '0;
            clamp_r  <= 1'b0;
            run_bad  <= 1'b0;
            clr_err  <= 1'b0;
            err_r    <= 1'b0;
            finished <= 1'b0;
            clamped  <= 1'b0;
            e_cur    <= '0;
            adj_val  <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                e_prev[i]   <= '0;
                adj_prev[i] <= '0;
            end
        end else begin
            clr_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clr) begin
                        if (ch_ok) begin
                            e_prev[ch]   <= '0;
                            adj_prev[ch] <= '0;
                        end else begin
                            clr_err <= 1'b1;
                        end
                    end else if (arm) begin
                        ch_r <= ch;
                        if (ch_ok) begin
                            run_bad <= 1'b0;
                            err_r   <= 1'b0;
                            p_r     <= cl_P;
                            i_r     <= cl_I;
                            e_cur   <= EW'(setpt) - EW'(measured);
                            mcand   <= ext2(SEC_PER_CYCLE);
                            mplier  <= {{(W-CYCLE_COUNT_WID-CONSTS_FRAC){1'b0}},
                                        cycles, {CONSTS_FRAC{1'b0}}};
                            acc     <= '0;
                            cnt     <= CW'(W-1);
                        end else begin
                            run_bad <= 1'b1;
                            err_r   <= 1'b1;
                        end
                    end
                end
                S_DT, S_IDT, S_EPIDT, S_EP: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand <<< 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (mul_last) begin
                        acc <= '0;
                        cnt <= CW'(W-1);
                        case (state)
                            S_DT: begin
                                mcand  <= ext2(i_r);
                                mplier <= p_sat;
                            end
                            S_IDT: begin
                                mcand  <= ext2(sat_add(p_r, p_sat));
                                mplier <= to_q(e_cur);
                            end
                            S_EPIDT: begin
                                a_r    <= p_sat;
                                mcand  <= ext2(p_r);
                                mplier <= to_q(e_prev[ch_r]);
                            end
                            default: b_r <= p_sat;
                        endcase
                    end
                end
                S_SUM: s_r <= s_nxt;
                S_CLAMP: begin
                    adj_r   <= adj_c;
                    clamp_r <= hit;
                end
                S_DONE: begin
                    // finished low marks the first DONE clock: commit exactly once.
                    if (!finished) begin
                        finished <= 1'b1;
                        if (!run_bad) begin
                            adj_val        <= adj_r;
                            clamped        <= clamp_r;
                            e_prev[ch_r]   <= e_cur;
                            adj_prev[ch_r] <= adj_r;
                        end
                    end else if (!arm) begin
                        finished <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_loop_math_mc.sv
// Directed bench for control_loop_math_mc: two instances share the stimulus,
// one with default parameters and one with dt=1.0 and +/-25.0 output limits.
module tb_control_loop_math_mc;

    localparam int W   = 64;
    localparam int NCH = 3;
    localparam logic signed [63:0] ONE  = 64'h0000_0800_0000_0000;
    localparam logic signed [63:0] HALF = 64'h0000_0400_0000_0000;
    localparam logic signed [63:0] LIM  = 64'h0000_C800_0000_0000;

    logic clk = 1'b0;
    logic rst_L = 1'b0;
    logic arm = 1'b0;
    logic clr = 1'b0;
    logic [1:0] ch = '0;
    logic signed [17:0] setpt = '0, measured = '0;
    logic signed [63:0] cl_P = '0, cl_I = '0;
    logic [17:0] cycles = '0;

    logic fin_a, err_a, clp_a, fin_b, err_b, clp_b;
    logic signed [18:0] ecur_a, ecur_b;
    logic signed [63:0] adj_a, adj_b;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;

    always #5 clk = ~clk;

    control_loop_math_mc #(.NCH(NCH)) u_a (
        .clk(clk), .rst_L(rst_L), .arm(arm), .ch(ch), .clr(clr),
        .setpt(setpt), .measured(measured), .cl_P(cl_P), .cl_I(cl_I),
        .cycles(cycles), .finished(fin_a), .err(err_a), .clamped(clp_a),
        .e_cur(ecur_a), .adj_val(adj_a)
    );

    control_loop_math_mc #(.NCH(NCH), .SEC_PER_CYCLE(ONE), .ADJ_MAX(LIM), .ADJ_MIN(-LIM)) u_b (
        .clk(clk), .rst_L(rst_L), .arm(arm), .ch(ch), .clr(clr),
        .setpt(setpt), .measured(measured), .cl_P(cl_P), .cl_I(cl_I),
        .cycles(cycles), .finished(fin_b), .err(err_b), .clamped(clp_b),
        .e_cur(ecur_b), .adj_val(adj_b)
    );

    function automatic logic signed [63:0] q(input int n);
        q = longint'(n) <<< 43;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One run; inputs are scrambled right after acceptance to prove latching.
    task automatic run(input int c, input int e, input logic signed [63:0] p,
                       input logic signed [63:0] i, input int cyc,
                       input bit keep_arm, input bit with_clr, output int l);
        @(negedge clk);
        ch = 2'(c);
        setpt = 18'(e + 1000);
        measured = 18'(1000);
        cl_P = p;
        cl_I = i;
        cycles = 18'(cyc);
        arm = 1'b1;
        clr = with_clr;
        if (with_clr) begin
            @(posedge clk);
            @(negedge clk);
            clr = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        if (!keep_arm) arm = 1'b0;
        setpt = 18'(777);
        measured = 18'(-333);
        cl_P = 64'sd12345;
        cl_I = -ONE;
        cycles = 18'(99);
        ch = 2'd0;
        l = 0;
        while (l < 400) begin
            @(posedge clk);
            l++;
            #1;
            if (fin_a) break;
        end
        chk("fin_seen", fin_a, 1);
        if (keep_arm) begin
            repeat (3) @(posedge clk);
            #1 chk("fin_hold", fin_a, 1);
            @(negedge clk);
            arm = 1'b0;
        end
        @(posedge clk);
        #1 chk("fin_drop", fin_a, 0);
    endtask

    task automatic do_clr(input int c);
        @(negedge clk);
        clr = 1'b1;
        ch = 2'(c);
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fin", fin_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_clp", clp_a, 0);
        chk("rst_ecur", ecur_a, 0);
        chk("rst_adj", adj_a, 0);
        @(negedge clk);
        rst_L = 1'b1;

        // proportional only, ch0
        run(0, 100, ONE, 0, 5, 1, 0, lat);
        chk("t1_latency", lat, 4*W+3);
        chk("t1_adj_a", adj_a, q(100));
        chk("t1_ecur_a", ecur_a, 100);
        chk("t1_clp_a", clp_a, 0);
        chk("t1_adj_b", adj_b, q(25));
        chk("t1_clp_b", clp_b, 1);
        run(0, 100, ONE, 0, 5, 0, 0, lat);
        chk("t1r_adj_a", adj_a, q(100));
        chk("t1r_adj_b", adj_b, q(25));
        chk("t1r_clp_b", clp_b, 0);

        // integral only, ch2; default dt on u_a is 87960 LSB per clock
        run(2, 10, 0, HALF, 2, 0, 0, lat);
        chk("t2a_adj_b", adj_b, q(10));
        chk("t2a_adj_a", adj_a, 879600);
        run(2, 10, 0, HALF, 2, 0, 0, lat);
        chk("t2b_adj_b", adj_b, q(20));
        chk("t2b_adj_a", adj_a, 1759200);
        run(2, 10, 0, HALF, 2, 0, 0, lat);
        chk("t3_adj_b", adj_b, q(25));
        chk("t3_clp_b", clp_b, 1);
        chk("t3_adj_a", adj_a, 2638800);
        chk("t3_clp_a", clp_a, 0);
        run(2, -10, 0, HALF, 2, 0, 0, lat);
        chk("t3n_adj_b", adj_b, q(15));
        chk("t3n_clp_b", clp_b, 0);
        chk("t3n_adj_a", adj_a, 1759200);
        chk("t3n_ecur_b", ecur_b, -10);

        // interleaved channels, P=1.0 I=0.5 dt=2.0: adj = adj_prev + 2e - e_prev
        do_clr(0);
        run(1, 3, ONE, HALF, 2, 0, 0, lat);
        chk("t4_ch1_a", adj_b, q(6));
        run(0, 4, ONE, HALF, 2, 0, 0, lat);
        chk("t4_ch0_a", adj_b, q(8));
        run(1, 2, ONE, HALF, 2, 0, 0, lat);
        chk("t4_ch1_b", adj_b, q(7));
        run(0, 1, ONE, HALF, 2, 0, 0, lat);
        chk("t4_ch0_b", adj_b, q(6));
        do_clr(1);
        run(1, 2, ONE, HALF, 2, 0, 0, lat);
        chk("t4_ch1_clr", adj_b, q(4));
        run(0, 1, ONE, HALF, 2, 0, 0, lat);
        chk("t4_ch0_keep", adj_b, q(7));

        // out-of-range channel
        run(3, 50, ONE, HALF, 2, 0, 0, lat);
        chk("t5_latency", lat, 1);
        chk("t5_err_b", err_b, 1);
        chk("t5_err_a", err_a, 1);
        chk("t5_adj_hold", adj_b, q(7));
        run(0, 1, ONE, HALF, 2, 0, 0, lat);
        chk("t5_nochg", adj_b, q(8));
        chk("t5_err_clr", err_b, 0);

        @(negedge clk);
        clr = 1'b1;
        ch = 2'd3;
        @(posedge clk);
        #1 chk("clr_err_on", err_b, 1);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1 chk("clr_err_off", err_b, 0);

        // clr and arm together: clear first, run one clock later
        run(1, 5, ONE, HALF, 2, 0, 1, lat);
        chk("clrarm_latency", lat, 4*W+3);
        chk("clrarm_adj", adj_b, q(10));

        // reset in the middle of a run
        @(negedge clk);
        ch = 2'd0;
        setpt = 18'(9);
        measured = 18'(0);
        cl_P = ONE;
        cl_I = HALF;
        cycles = 18'(2);
        arm = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arm = 1'b0;
        repeat (100) @(posedge clk);
        #1 rst_L = 1'b0;
        #1;
        chk("t6_fin", fin_a, 0);
        chk("t6_err", err_a, 0);
        chk("t6_clp", clp_a, 0);
        chk("t6_ecur", ecur_a, 0);
        chk("t6_adj_a", adj_a, 0);
        chk("t6_adj_b", adj_b, 0);
        @(negedge clk);
        rst_L = 1'b1;
        run(0, 3, ONE, HALF, 2, 0, 0, lat);
        chk("t6_fresh", adj_b, q(6));
        chk("t6_ecur_b", ecur_b, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
